// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-and-add multiplier controller producing the low XLEN bits
// of op_a * op_b (RV32M MUL). It borrows the execute-stage ALU for the accumulate step: it
// raises alu_req, drives alu_a/alu_b with ADD, and consumes alu_res on cycles where
// alu_grant is high. Shifting of the multiplicand and multiplier is done locally.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, op_a, op_b    request and operands, accepted only while ready=1
//   ready                high in IDLE only
//   done, result, ack    result valid (held until ack), product, consumer acknowledge
//   alu_req, alu_grant   ALU request / grant handshake with the pipeline
//   alu_a, alu_b         ALU operands (prod and mcand while running, zero otherwise)
//   alu_op, alu_mod      ALU operation select, fixed to ADD / 0
//   alu_res              combinational ALU result
module alu_mul_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            ready,
  output logic            done,
  input  logic            ack,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_grant,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_mod,
  input  logic [XLEN-1:0] alu_res
);

  localparam int unsigned    CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [2:0]     AluAdd  = 3'd0;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          prod_d   = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          if (EARLY_EXIT && (op_b == '0)) begin
            state_d  = StDone;
            result_d = '0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Without a grant every register holds, so stalls never disturb the product.
        if (alu_grant) begin
          if (mplier_q[0]) prod_d = alu_res;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if ((cnt_q == CntLast) || (EARLY_EXIT && (mplier_d == '0))) begin
            state_d  = StDone;
            result_d = prod_d;
          end
        end
      end
      StDone: begin
        // A start arriving together with ack is deliberately dropped: ready is low here.
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    ready   = (state_q == StIdle);
    done    = (state_q == StDone);
    alu_req = (state_q == StRun);
    alu_a   = alu_req ? prod_q  : '0;
    alu_b   = alu_req ? mcand_q : '0;
    alu_op  = AluAdd;
    alu_mod = 1'b0;
    result  = result_q;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: instance 0 has EARLY_EXIT=1, instance 1 has EARLY_EXIT=0.
// Each instance is paired with an ideal adder acting as the execute-stage ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start, ack, grant, ready, done, alu_req, alu_mod;
  logic [31:0] op_a[2], op_b[2], result[2], alu_a[2], alu_b[2], alu_res[2];
  logic [2:0]  alu_op[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_mul_sequencer #(
      .XLEN      (32),
      .EARLY_EXIT(g == 0)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .op_a     (op_a[g]),
      .op_b     (op_b[g]),
      .ready    (ready[g]),
      .done     (done[g]),
      .ack      (ack[g]),
      .result   (result[g]),
      .alu_req  (alu_req[g]),
      .alu_grant(grant[g]),
      .alu_a    (alu_a[g]),
      .alu_b    (alu_b[g]),
      .alu_op   (alu_op[g]),
      .alu_mod  (alu_mod[g]),
      .alu_res  (alu_res[g])
    );
    assign alu_res[g] = alu_a[g] + alu_b[g];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Iterations the specification demands for multiplier b.
  function automatic int exp_iters(input int s, input logic [31:0] b);
    int n;
    if (s == 1) return 32;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Partial product after k iterations: a times the low k bits of b.
  function automatic logic [31:0] partial(input logic [31:0] a, input logic [31:0] b,
                                          input int k);
    logic [63:0] mb;
    mb = (k >= 32) ? {32'd0, b} : ({32'd0, b} & ((64'd1 << k) - 64'd1));
    return 32'({32'd0, a} * mb);
  endfunction

  function automatic logic [31:0] shifted(input logic [31:0] a, input int k);
    return (k >= 32) ? 32'd0 : (a << k);
  endfunction

  task automatic check_idle_outputs(input int s, input string tag);
    check({tag, "_ready"}, 32'(ready[s]), 32'd1);
    check({tag, "_done"}, 32'(done[s]), 32'd0);
    check({tag, "_alu_req"}, 32'(alu_req[s]), 32'd0);
    check({tag, "_alu_a"}, alu_a[s], 32'd0);
    check({tag, "_alu_b"}, alu_b[s], 32'd0);
  endtask

  // Runs one multiplication; rnd enables random grant stalls and random noise on
  // start/ack/operands while busy. Returns at the negedge where done is first seen.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b, input bit rnd);
    int    iter, stalls, cycles, need;
    logic  g;
    need = exp_iters(s, b);
    @(negedge clk);
    check("ready_before_start", 32'(ready[s]), 32'd1);
    start[s] = 1'b1;
    op_a[s]  = a;
    op_b[s]  = b;
    ack[s]   = 1'b0;
    @(negedge clk);
    cycles = 1;
    iter   = 0;
    stalls = 0;
    while (!done[s] && cycles < 400) begin
      check("run_alu_req", 32'(alu_req[s]), 32'd1);
      check("run_ready", 32'(ready[s]), 32'd0);
      check("run_alu_a", alu_a[s], partial(a, b, iter));
      check("run_alu_b", alu_b[s], shifted(a, iter));
      check("run_alu_op", {29'd0, alu_op[s]}, 32'd0);
      g        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      grant[s] = g;
      start[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      ack[s]   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      op_a[s]  = $urandom;
      op_b[s]  = $urandom;
      if (g) iter++;
      else stalls++;
      @(negedge clk);
      cycles++;
    end
    start[s] = 1'b0;
    ack[s]   = 1'b0;
    grant[s] = 1'b0;
    check("done_seen", 32'(done[s]), 32'd1);
    check("iterations", 32'(iter), 32'(need));
    check("latency", 32'(cycles), 32'(need + stalls + 1));
    check("result", result[s], 32'({32'd0, a} * {32'd0, b}));
    check("done_ready", 32'(ready[s]), 32'd0);
  endtask

  task automatic ack_op(input int s);
    logic [31:0] held;
    held   = result[s];
    ack[s] = 1'b1;
    @(negedge clk);
    ack[s] = 1'b0;
    check_idle_outputs(s, "after_ack");
    check("after_ack_result_held", result[s], held);
  endtask

  initial begin
    logic [31:0] a, b, r;
    reset = 1'b1;
    start = '0;
    ack   = '0;
    grant = '0;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check_idle_outputs(s, "reset");
      check("reset_result", result[s], 32'd0);
      check("reset_alu_mod", 32'(alu_mod[s]), 32'd0);
    end

    // Early-exit directed cases.
    run_op(0, 32'd7, 32'd6, 1'b0);
    ack_op(0);
    run_op(0, 32'd5, 32'd0, 1'b0);
    ack_op(0);

    // Full-length directed cases.
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    ack_op(1);
    run_op(1, 32'h8000_0000, 32'd2, 1'b0);
    ack_op(1);
    run_op(1, 32'd9, 32'd0, 1'b0);
    ack_op(1);

    // Grant stalls.
    run_op(0, 32'd123, 32'd456, 1'b1);
    ack_op(0);
    run_op(1, 32'd123, 32'd456, 1'b1);
    ack_op(1);

    // Random operands with random stalls on both variants.
    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(n % 2, a, b, 1'b1);
      ack_op(n % 2);
    end

    // Handshake: done held without ack, extra starts ignored, start+ack only returns to idle.
    run_op(0, 32'd1000, 32'd77, 1'b0);
    r = 32'd77000;
    for (int i = 0; i < 10; i++) begin
      start[0] = 1'b1;
      op_a[0]  = $urandom;
      op_b[0]  = $urandom;
      @(negedge clk);
      check("hold_done", 32'(done[0]), 32'd1);
      check("hold_ready", 32'(ready[0]), 32'd0);
      check("hold_result", result[0], r);
    end
    start[0] = 1'b1;
    ack[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ack[0]   = 1'b0;
    check_idle_outputs(0, "start_ack");
    @(negedge clk);
    check_idle_outputs(0, "start_ack_no_op");
    run_op(0, 32'd3, 32'd5, 1'b0);
    ack_op(0);

    // Reset in the middle of a run.
    @(negedge clk);
    start[0] = 1'b1;
    op_a[0]  = 32'd50;
    op_b[0]  = 32'h0000_FFFF;
    @(negedge clk);
    start[0] = 1'b0;
    grant[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_run_alu_b", alu_b[0], 32'd50 << 5);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    grant[0] = 1'b0;
    check_idle_outputs(0, "mid_reset");
    check("mid_reset_result", result[0], 32'd0);
    run_op(0, 32'd10, 32'd10, 1'b0);
    ack_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
